// File: rtl/mips_mem_pkg.sv
// Shared constants and FSM encoding for the MIPS data-memory responder.
package mips_mem_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mips_dmem_array.sv
// DEPTH x 32 word storage: preloaded with mem[i]=i on reset, one write port,
// one registered read port whose output register can be cleared.
module mips_dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              rclr,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Word storage with reset preload and single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_W'(i);
            end
        end else if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port; rclr forces the output back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else if (rclr) begin
            rdata_r <= {DATA_W{1'b0}};
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: one LW/SW at a time with a fixed access latency.
// Optional DMEM_BYTE_ADDR_EN: treat req_addr as a byte address with alignment check.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_e             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               accept_s, enter_resp_s, leave_resp_s;

    logic               we_r, err_r;
    logic [AW-1:0]      idx_r;
    logic [DATA_W-1:0]  wdata_r;

    logic [DATA_W-1:0]  idx_s;
    logic               misalign_s, err_s;

    logic               cur_we_s, cur_err_s;
    logic [AW-1:0]      cur_idx_s;
    logic [DATA_W-1:0]  cur_wdata_s;

    logic               req_ready_r, rsp_valid_r, rsp_err_r, busy_r;
    logic               mem_we_s, mem_re_s, mem_rclr_s;

`ifdef DMEM_BYTE_ADDR_EN
    assign idx_s      = {2'b00, req_addr[31:2]};
    assign misalign_s = (req_addr[1:0] != 2'b00);
`else
    assign idx_s      = req_addr;
    assign misalign_s = 1'b0;
`endif
    assign err_s = misalign_s | (idx_s >= DATA_W'(DEPTH));

    // With LATENCY==1 the access happens on the accept edge, before the latch is loaded.
    assign cur_we_s    = (state_r == IDLE) ? req_we          : we_r;
    assign cur_err_s   = (state_r == IDLE) ? err_s           : err_r;
    assign cur_idx_s   = (state_r == IDLE) ? idx_s[AW-1:0]   : idx_r;
    assign cur_wdata_s = (state_r == IDLE) ? req_wdata       : wdata_r;

    // Next-state and event decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        leave_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    cnt_s    = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_s      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                cnt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_s      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s      = IDLE;
                    leave_resp_s = 1'b1;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request latch, loaded on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            idx_r   <= {AW{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            we_r    <= req_we;
            err_r   <= err_s;
            idx_r   <= idx_s[AW-1:0];
            wdata_r <= req_wdata;
        end
    end

    // Registered handshake/status outputs follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            req_ready_r <= (state_s == IDLE);
            rsp_valid_r <= (state_s == RESP);
            busy_r      <= (state_s != IDLE);
            if (enter_resp_s) begin
                rsp_err_r <= cur_err_s;
            end else if (leave_resp_s) begin
                rsp_err_r <= 1'b0;
            end
        end
    end

    // Faulted accesses neither write nor read; stores and faults return zero.
    assign mem_we_s   = enter_resp_s &  cur_we_s & ~cur_err_s;
    assign mem_re_s   = enter_resp_s & ~cur_we_s & ~cur_err_s;
    assign mem_rclr_s = (enter_resp_s & (cur_we_s | cur_err_s)) | leave_resp_s;

    mips_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .rclr  (mem_rclr_s),
        .addr  (cur_idx_s),
        .wdata (cur_wdata_s),
        .rdata (rsp_rdata)
    );

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: one LATENCY=2 and one LATENCY=1 instance.
module tb_mips_dmem_responder;

    localparam int DEPTH = 32;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat_cfg [2];
    exp_t        sb [$];
    logic [31:0] mdl [2][DEPTH];

    always #5 clk = ~clk;

    mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wa(input int idx);
`ifdef DMEM_BYTE_ADDR_EN
        return 32'(idx) << 2;
`else
        return 32'(idx);
`endif
    endfunction

    task automatic reset_models();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mdl[s][i] = 32'(i);
            end
        end
    endtask

    // One full transaction on instance s; response held hold cycles before consuming.
    task automatic txn(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input string tag);
        logic [31:0] idx;
        logic        err;
        exp_t        e;
        logic [31:0] held;
        int          lat;
`ifdef DMEM_BYTE_ADDR_EN
        idx = addr >> 2;
        err = (addr[1:0] != 2'b00);
`else
        idx = addr;
        err = 1'b0;
`endif
        err     = err | (idx >= 32'(DEPTH));
        e.err   = err;
        e.rdata = 32'h0;
        if (!err) begin
            if (we) mdl[s][idx[4:0]] = wdata;
            else    e.rdata = mdl[s][idx[4:0]];
        end
        sb.push_back(e);

        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        rsp_ready[s] = (hold == 0);
        lat = 0;
        while (!req_ready[s] && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "/req_ready_idle"}, 32'(req_ready[s]), 32'd1);
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        check({tag, "/req_ready_after_accept"}, 32'(req_ready[s]), 32'd0);

        lat = 1;
        while (!rsp_valid[s] && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(lat_cfg[s]));
        e = sb.pop_front();
        if (rsp_valid[s]) begin
            held = rsp_rdata[s];
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                check({tag, "/hold_valid"}, 32'(rsp_valid[s]), 32'd1);
                check({tag, "/hold_rdata"}, rsp_rdata[s], held);
                check({tag, "/hold_req_ready"}, 32'(req_ready[s]), 32'd0);
            end
            check({tag, "/rdata"}, rsp_rdata[s], e.rdata);
            check({tag, "/err"}, 32'(rsp_err[s]), 32'(e.err));
            rsp_ready[s] = 1'b1;
            @(posedge clk); #1;
            rsp_ready[s] = 1'b0;
            check({tag, "/valid_cleared"}, 32'(rsp_valid[s]), 32'd0);
            check({tag, "/rdata_cleared"}, rsp_rdata[s], 32'd0);
            check({tag, "/back_to_idle"}, 32'(req_ready[s]), 32'd1);
        end
    endtask

    initial begin
        lat_cfg[0] = 2;
        lat_cfg[1] = 1;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        reset_models();
        @(posedge clk); @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            check("reset/req_ready", 32'(req_ready[s]), 32'd1);
            check("reset/rsp_valid", 32'(rsp_valid[s]), 32'd0);
            check("reset/rsp_rdata", rsp_rdata[s], 32'd0);
            check("reset/rsp_err",   32'(rsp_err[s]), 32'd0);
            check("reset/busy",      32'(busy[s]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        txn(0, 1'b0, wa(5), 32'h0, 0, "t1_load5");
        txn(0, 1'b1, wa(7), 32'hDEADBEEF, 0, "t2_store7");
        txn(0, 1'b0, wa(7), 32'h0, 0, "t2_load7");
        txn(0, 1'b0, wa(3), 32'h0, 4, "t3_load3_hold");
        txn(0, 1'b0, wa(40), 32'h0, 0, "t4_load40");
        txn(0, 1'b1, wa(40), 32'hCAFEF00D, 0, "t4_store40");
        txn(0, 1'b0, wa(8), 32'h0, 1, "t4_load8");
        txn(0, 1'b0, wa(31), 32'h0, 0, "t4_load31_edge");
        txn(0, 1'b0, wa(32), 32'h0, 0, "t4_load32_edge");

        // Reset while a store is waiting: it must not commit.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = wa(9);
        req_wdata[0] = 32'h1234;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("t5/busy_in_wait", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("t5/req_ready_async", 32'(req_ready[0]), 32'd1);
        check("t5/busy_async", 32'(busy[0]), 32'd0);
        check("t5/rsp_valid_async", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        reset_models();
        @(posedge clk); #1;
        txn(0, 1'b0, wa(9), 32'h0, 0, "t5_load9");
        txn(0, 1'b0, wa(7), 32'h0, 0, "t5_load7_preload");

        txn(1, 1'b0, wa(4), 32'h0, 0, "t6_load4");
        txn(1, 1'b1, wa(12), 32'h55AA55AA, 0, "t6_store12");
        txn(1, 1'b0, wa(12), 32'h0, 0, "t6_load12");
        txn(1, 1'b0, wa(33), 32'h0, 2, "t6_load33");
        for (int k = 0; k < 8; k++) begin
            txn(1, 1'($urandom_range(0, 1)), wa(int'($urandom_range(0, 35))),
                $urandom, int'($urandom_range(0, 2)), "t6_rand");
        end
`ifdef DMEM_BYTE_ADDR_EN
        txn(1, 1'b0, 32'h6, 32'h0, 0, "t6_misaligned");
        txn(1, 1'b1, 32'h9, 32'hFFFF0000, 0, "t6_misaligned_store");
        txn(1, 1'b0, 32'h8, 32'h0, 0, "t6_aligned8");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
